branch_update_ctrl: RTL and testbench
=====================================

// Module: branch_update_ctrl
// PURPOSE
//  Sequencer in front of predictor_bht, between fetch and the BHT. Serialises fetch
//  lookups (predict) and execute-stage resolutions (update) so both never pulse together.
//  Tracks in-flight predictions in an in-order queue and flags mispredictions.
//  Keeps saturating branch and mispredict statistics.
// PARAMETERS
//  ADDR_W  11  branch address width (matches BHT tag+index)
//  DEPTH    4  max unresolved predictions in flight (power of 2, >=2)
//  CNT_W   16  statistics counter width
// PORTS
//  clock             in   1       single clock, rising edge
//  reset_n           in   1       asynchronous, active-low reset
//  fetch_valid       in   1       fetch requests a prediction for fetch_addr
//  fetch_addr        in   ADDR_W  branch address to predict
//  fetch_ready       out  1       comb; request accepted this cycle
//  pred_valid        out  1       1-cycle pulse: pred_taken/pred_addr valid
//  pred_taken        out  1       predicted direction
//  pred_addr         out  ADDR_W  address the prediction belongs to
//  resolve_valid     in   1       execute resolved the oldest in-flight branch
//  resolve_taken     in   1       actual direction
//  resolve_ready     out  1       comb; resolution accepted this cycle
//  bp_predict        out  1       to BHT predict
//  bp_update         out  1       to BHT update
//  bp_addr           out  ADDR_W  to BHT branch_addr
//  bp_result         out  1       to BHT branch_result
//  bp_prediction     in   1       from BHT prediction (valid 1 cycle after bp_predict)
//  mispredict        out  1       registered 1-cycle pulse
//  mispredict_addr   out  ADDR_W  address of mispredicted branch (held until next pulse)
//  branch_count      out  CNT_W   resolved branches, saturating
//  mispredict_count  out  CNT_W   mispredictions, saturating
// BEHAVIOUR
//  - Reset: queue empty, no predict in flight, all outputs 0, counters 0.
//  - bp_predict, bp_update, bp_addr and bp_result are combinational from the arbiter.
//  - Arbitration each cycle, update wins over predict:
//    (a) resolve_valid & queue non-empty: bp_update=1, bp_addr=head.addr,
//        bp_result=resolve_taken, resolve_ready=1, fetch_ready=0, pop head.
//    (b) else fetch_valid & (occupancy + inflight) < DEPTH: bp_predict=1, bp_addr=fetch_addr,
//        fetch_ready=1, inflight<=1, latch fetch_addr.
//    (c) else both ready=0. bp_predict & bp_update are never both 1.
//  - Queue empty: resolve_ready=0; resolve_valid waits, including when a predict is in flight.
//  - Predict latency 1: in the cycle after (b), push {latched addr, bp_prediction};
//    pred_valid=1 with pred_taken=bp_prediction and pred_addr=latched addr (comb pass-through).
//  - Push and pop in the same cycle are legal; occupancy is unchanged.
//  - Mispredict: compare head.taken != resolve_taken in the cycle (a) fires.
//    On a miss, at that edge: flush the whole queue, drop any same-cycle push, suppress
//    pred_valid, clear inflight. Next cycle: mispredict=1, mispredict_addr=head.addr.
//  - Counters: on each (a), branch_count++; on each miss, mispredict_count++;
//    both hold at all-ones.
//  - Reset mid-operation discards queue, in-flight state and pulses immediately.
// STRUCTURE
//  - bp_defs.vh: ADDR_W default, entry layout {addr, taken}, ENTRY_W = ADDR_W+1.
//  - Sub-module bp_fifo: DEPTH x ENTRY_W sync FIFO with push, pop, flush, count,
//    full, empty and head data. Pointers wrap modulo DEPTH; flush has priority over push.
//  - Top holds the arbiter, the inflight flag and address latch, the compare and counters.
// TESTING
//  1. Reset, fetch 0x123 with BHT miss -> bp_predict 1 cycle; next cycle pred_valid,
//     pred_taken=1, pred_addr=0x123; occupancy 1.
//  2. Resolve taken on queue from (1) -> bp_update, bp_addr=0x123, bp_result=1;
//     no mispredict; branch_count=1.
//  3. fetch_valid and resolve_valid in the same cycle -> update first with fetch_ready=0;
//     predict next cycle; never both strobes high.
//  4. Fill 4 predictions; 5th fetch_valid -> fetch_ready=0 until a resolve pops.
//  5. 3 queued (taken), resolve oldest not-taken -> mispredict pulse,
//     mispredict_addr=oldest, queue empty, mispredict_count=1.
//  6. Preload counters near max and force 2 more misses -> both counters stay 0xFFFF.
//     Assert reset_n low mid-queue -> empty and outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/branch_update_ctrl_pkg.sv
// Shared defaults and types for the branch update sequencer and its in-flight queue.
// A queue entry is packed as {addr, taken}, with the taken bit in the LSB.
package branch_update_ctrl_pkg;

   localparam int unsigned ADDR_W_DEF     = 11;
   localparam int unsigned DEPTH_DEF      = 4;
   localparam int unsigned CNT_W_DEF      = 16;
   localparam int unsigned ENTRY_TAKEN_LSB = 0;

   typedef enum logic [1:0] {
      GNT_NONE    = 2'd0,
      GNT_UPDATE  = 2'd1,
      GNT_PREDICT = 2'd2
   } grant_e;

endpackage

// File: rtl/bp_fifo.sv
// In-order queue of unresolved predictions: synchronous FIFO with flush and occupancy count.
// Flush takes priority over any push or pop in the same cycle.
module bp_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 12
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic                       i_flush,
   input  logic [WIDTH-1:0]           i_data,
   output logic [WIDTH-1:0]           o_head,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_full,
   output logic                       o_empty
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_pop;
   logic             w_do_push;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CW'(DEPTH));
   assign o_count   = r_count;
   assign o_head    = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   // DEPTH is a power of two, so the pointers wrap modulo DEPTH by overflow.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
         else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/branch_update_ctrl.sv
// Sequencer between fetch/execute and the BHT: arbitrates predict vs. update strobes,
// tracks in-flight predictions in order, flags mispredictions and keeps saturating stats.
module branch_update_ctrl
   import branch_update_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DEPTH  = DEPTH_DEF,
   parameter int unsigned CNT_W  = CNT_W_DEF
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              fetch_valid,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_ready,
   output logic              pred_valid,
   output logic              pred_taken,
   output logic [ADDR_W-1:0] pred_addr,
   input  logic              resolve_valid,
   input  logic              resolve_taken,
   output logic              resolve_ready,
   output logic              bp_predict,
   output logic              bp_update,
   output logic [ADDR_W-1:0] bp_addr,
   output logic              bp_result,
   input  logic              bp_prediction,
   output logic              mispredict,
   output logic [ADDR_W-1:0] mispredict_addr,
   output logic [CNT_W-1:0]  branch_count,
   output logic [CNT_W-1:0]  mispredict_count
);

   localparam int unsigned ENTRY_W = ADDR_W + 1;
   localparam int unsigned CW      = $clog2(DEPTH) + 1;

   grant_e              w_grant;
   logic [ENTRY_W-1:0]  w_head;
   logic [ADDR_W-1:0]   w_head_addr;
   logic                w_head_taken;
   logic [CW-1:0]       w_count;
   logic [CW-1:0]       w_occupied;
   logic                w_full;
   logic                w_empty;
   logic                w_miss;
   logic                w_push;

   logic                r_inflight;
   logic [ADDR_W-1:0]   r_lat_addr;
   logic                r_mispredict;
   logic [ADDR_W-1:0]   r_mispredict_addr;
   logic [CNT_W-1:0]    r_branch_count;
   logic [CNT_W-1:0]    r_mispredict_count;

   bp_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .i_push  (w_push),
      .i_pop   (bp_update),
      .i_flush (w_miss),
      .i_data  ({r_lat_addr, bp_prediction}),
      .o_head  (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign w_head_addr  = w_head[ENTRY_W-1:1];
   assign w_head_taken = w_head[ENTRY_TAKEN_LSB];
   // An issued predict has reserved a slot even before its entry lands in the queue.
   assign w_occupied   = w_count + CW'(r_inflight);

   always_comb begin
      w_grant = GNT_NONE;
      if (resolve_valid && !w_empty)
         w_grant = GNT_UPDATE;
      else if (fetch_valid && !w_full && (w_occupied < CW'(DEPTH)))
         w_grant = GNT_PREDICT;
   end

   always_comb begin
      bp_update     = 1'b0;
      bp_predict    = 1'b0;
      bp_addr       = '0;
      bp_result     = 1'b0;
      case (w_grant)
         GNT_UPDATE: begin
            bp_update = 1'b1;
            bp_addr   = w_head_addr;
            bp_result = resolve_taken;
         end
         GNT_PREDICT: begin
            bp_predict = 1'b1;
            bp_addr    = fetch_addr;
         end
         default: ;
      endcase
   end

   assign resolve_ready = bp_update;
   assign fetch_ready   = bp_predict;

   assign w_miss     = bp_update && (w_head_taken != resolve_taken);
   assign w_push     = r_inflight && !w_miss;
   assign pred_valid = w_push;
   assign pred_taken = w_push && bp_prediction;
   assign pred_addr  = w_push ? r_lat_addr : '0;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_inflight         <= 1'b0;
         r_lat_addr         <= '0;
         r_mispredict       <= 1'b0;
         r_mispredict_addr  <= '0;
         r_branch_count     <= '0;
         r_mispredict_count <= '0;
      end else begin
         r_inflight   <= bp_predict && !w_miss;
         r_mispredict <= w_miss;
         if (bp_predict) r_lat_addr <= fetch_addr;
         if (w_miss) r_mispredict_addr <= w_head_addr;
         if (bp_update && (r_branch_count != '1))
            r_branch_count <= r_branch_count + 1'b1;
         if (w_miss && (r_mispredict_count != '1))
            r_mispredict_count <= r_mispredict_count + 1'b1;
      end
   end

   assign mispredict       = r_mispredict;
   assign mispredict_addr  = r_mispredict_addr;
   assign branch_count     = r_branch_count;
   assign mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_update_ctrl.sv
// Randomized and directed bench for branch_update_ctrl against a queue-based reference model.
module tb_branch_update_ctrl;

   localparam int unsigned AW   = 11;
   localparam int unsigned DP   = 4;
   localparam int unsigned CW   = 8;
   localparam int unsigned CMAX = (1 << CW) - 1;

   logic          clock;
   logic          reset_n;
   logic          fetch_valid;
   logic [AW-1:0] fetch_addr;
   logic          fetch_ready;
   logic          pred_valid;
   logic          pred_taken;
   logic [AW-1:0] pred_addr;
   logic          resolve_valid;
   logic          resolve_taken;
   logic          resolve_ready;
   logic          bp_predict;
   logic          bp_update;
   logic [AW-1:0] bp_addr;
   logic          bp_result;
   logic          bp_prediction;
   logic          mispredict;
   logic [AW-1:0] mispredict_addr;
   logic [CW-1:0] branch_count;
   logic [CW-1:0] mispredict_count;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   branch_update_ctrl #(
      .ADDR_W (AW),
      .DEPTH  (DP),
      .CNT_W  (CW)
   ) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .fetch_valid      (fetch_valid),
      .fetch_addr       (fetch_addr),
      .fetch_ready      (fetch_ready),
      .pred_valid       (pred_valid),
      .pred_taken       (pred_taken),
      .pred_addr        (pred_addr),
      .resolve_valid    (resolve_valid),
      .resolve_taken    (resolve_taken),
      .resolve_ready    (resolve_ready),
      .bp_predict       (bp_predict),
      .bp_update        (bp_update),
      .bp_addr          (bp_addr),
      .bp_result        (bp_result),
      .bp_prediction    (bp_prediction),
      .mispredict       (mispredict),
      .mispredict_addr  (mispredict_addr),
      .branch_count     (branch_count),
      .mispredict_count (mispredict_count)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct packed {
      logic [AW-1:0] addr;
      logic          taken;
   } ent_t;

   ent_t          mq[$];
   bit            m_inflight;
   logic [AW-1:0] m_lat;
   bit            m_misp;
   logic [AW-1:0] m_misp_addr;
   int unsigned   m_bc;
   int unsigned   m_mc;
   bit            pending;

   bit            e_upd, e_prd, e_miss, e_pv, e_bpr, e_ppred;
   logic [AW-1:0] e_bpa, e_fa;

   task automatic model_reset();
      mq.delete();
      m_inflight  = 0;
      m_lat       = '0;
      m_misp      = 0;
      m_misp_addr = '0;
      m_bc        = 0;
      m_mc        = 0;
      pending     = 0;
   endtask

   task automatic eval();
      e_upd   = resolve_valid && (mq.size() != 0);
      e_prd   = !e_upd && fetch_valid && ((mq.size() + int'(m_inflight)) < DP);
      e_miss  = e_upd && (mq[0].taken != resolve_taken);
      e_pv    = m_inflight && !e_miss;
      e_bpa   = e_upd ? mq[0].addr : fetch_addr;
      e_bpr   = resolve_taken;
      e_ppred = bp_prediction;
      e_fa    = fetch_addr;
   endtask

   task automatic commit();
      if (!pending) return;
      if (e_miss) begin
         m_misp_addr = mq[0].addr;
         mq.delete();
         m_misp = 1;
      end else begin
         m_misp = 0;
         if (e_upd) void'(mq.pop_front());
         if (e_pv) mq.push_back(ent_t'{addr: m_lat, taken: e_ppred});
      end
      if (e_upd && m_bc < CMAX) m_bc++;
      if (e_miss && m_mc < CMAX) m_mc++;
      m_inflight = e_prd;
      if (e_prd) m_lat = e_fa;
      pending = 0;
   endtask

   task automatic drive(input logic fv, input logic [AW-1:0] fa,
                        input logic rv, input logic rt, input logic bpp);
      commit();
      @(negedge clock);
      fetch_valid   = fv;
      fetch_addr    = fa;
      resolve_valid = rv;
      resolve_taken = rt;
      bp_prediction = bpp;
      #1;
      eval();
      pending = 1;
   endtask

   task automatic drain();
      for (int i = 0; i < 20; i++) begin
         commit();
         if (mq.size() == 0 && !m_inflight) break;
         drive(1'b0, '0, mq.size() != 0, (mq.size() != 0) ? mq[0].taken : 1'b0, 1'b0);
      end
      commit();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      fetch_valid = 1'b0; fetch_addr = '0; resolve_valid = 1'b0;
      resolve_taken = 1'b0; bp_prediction = 1'b0;
      model_reset();
      repeat (2) @(negedge clock);
      #1;
      n_checks++;
      if ({pred_valid, mispredict, bp_predict, bp_update, fetch_ready, resolve_ready,
           bp_addr, mispredict_addr, branch_count, mispredict_count} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got pv=%b mp=%b bpp=%b bpu=%b bpa=%h mpa=%h bc=%0d mc=%0d, want all 0",
                  pred_valid, mispredict, bp_predict, bp_update, bp_addr, mispredict_addr,
                  branch_count, mispredict_count);
      end
      reset_n = 1'b1;
   endtask

   task automatic test_predict();
      drive(1'b1, 11'h123, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if ({bp_predict, bp_update, fetch_ready, bp_addr} !== {1'b1, 1'b0, 1'b1, 11'h123}) begin
         n_fail++;
         $display("FAIL predict_issue: got bpp=%b bpu=%b fr=%b addr=%h, want 1 0 1 123",
                  bp_predict, bp_update, fetch_ready, bp_addr);
      end
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if ({pred_valid, pred_taken, pred_addr, bp_predict} !== {1'b1, 1'b1, 11'h123, 1'b0}) begin
         n_fail++;
         $display("FAIL predict_result: got pv=%b pt=%b pa=%h bpp=%b, want 1 1 123 0",
                  pred_valid, pred_taken, pred_addr, bp_predict);
      end
   endtask

   task automatic test_resolve();
      drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if ({bp_update, resolve_ready, bp_addr, bp_result, bp_predict} !== {1'b1, 1'b1, 11'h123, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL resolve_update: got bpu=%b rr=%b addr=%h res=%b bpp=%b, want 1 1 123 1 0",
                  bp_update, resolve_ready, bp_addr, bp_result, bp_predict);
      end
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if ({mispredict, resolve_ready, branch_count, mispredict_count} !== {1'b0, 1'b0, CW'(1), CW'(0)}) begin
         n_fail++;
         $display("FAIL resolve_stats: got mp=%b rr=%b bc=%0d mc=%0d, want 0 0 1 0",
                  mispredict, resolve_ready, branch_count, mispredict_count);
      end
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 11'h0A5, 1'b0, 1'b0, 1'b0);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 11'h3C3, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if ({bp_update, bp_predict, fetch_ready, resolve_ready, bp_addr} !== {1'b1, 1'b0, 1'b0, 1'b1, 11'h0A5}) begin
         n_fail++;
         $display("FAIL collide_update_first: got bpu=%b bpp=%b fr=%b rr=%b addr=%h, want 1 0 0 1 0a5",
                  bp_update, bp_predict, fetch_ready, resolve_ready, bp_addr);
      end
      drive(1'b1, 11'h3C3, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if ({bp_update, bp_predict, fetch_ready, bp_addr} !== {1'b0, 1'b1, 1'b1, 11'h3C3}) begin
         n_fail++;
         $display("FAIL collide_predict_next: got bpu=%b bpp=%b fr=%b addr=%h, want 0 1 1 3c3",
                  bp_update, bp_predict, fetch_ready, bp_addr);
      end
      drain();
   endtask

   task automatic test_full();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, AW'(11'h200 + i), 1'b0, 1'b0, 1'b1);
         n_checks++;
         if (fetch_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_accept[%0d]: got fr=%b want 1", i, fetch_ready);
         end
      end
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 11'h2FF, 1'b0, 1'b0, 1'b1);
         n_checks++;
         if ({fetch_ready, bp_predict} !== 2'b00) begin
            n_fail++;
            $display("FAIL full_block[%0d]: got fr=%b bpp=%b want 0 0", i, fetch_ready, bp_predict);
         end
      end
      drive(1'b1, 11'h2FF, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if ({resolve_ready, fetch_ready, bp_addr} !== {1'b1, 1'b0, 11'h200}) begin
         n_fail++;
         $display("FAIL full_pop: got rr=%b fr=%b addr=%h want 1 0 200", resolve_ready, fetch_ready, bp_addr);
      end
      drive(1'b1, 11'h2FF, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (fetch_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL full_reopen: got fr=%b want 1", fetch_ready);
      end
      drain();
   endtask

   task automatic test_mispredict();
      drive(1'b1, 11'h111, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 11'h222, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 11'h333, 1'b0, 1'b0, 1'b1);
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      n_checks++;
      if ({bp_update, bp_addr, bp_result} !== {1'b1, 11'h111, 1'b0}) begin
         n_fail++;
         $display("FAIL miss_update: got bpu=%b addr=%h res=%b want 1 111 0", bp_update, bp_addr, bp_result);
      end
      drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if ({mispredict, mispredict_addr, mispredict_count, resolve_ready} !== {1'b1, 11'h111, CW'(1), 1'b0}) begin
         n_fail++;
         $display("FAIL miss_pulse: got mp=%b mpa=%h mc=%0d rr=%b want 1 111 1 0",
                  mispredict, mispredict_addr, mispredict_count, resolve_ready);
      end
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if ({mispredict, mispredict_addr} !== {1'b0, 11'h111}) begin
         n_fail++;
         $display("FAIL miss_one_cycle: got mp=%b mpa=%h want 0 111", mispredict, mispredict_addr);
      end
      drain();
   endtask

   task automatic test_random();
      logic fv, rv, rt;
      for (int c = 0; c < 2000; c++) begin
         commit();
         fv = ($urandom_range(0, 3) != 0);
         rv = ($urandom_range(0, 1) != 0);
         rt = (mq.size() != 0 && $urandom_range(0, 4) != 0) ? mq[0].taken : 1'($urandom);
         drive(fv, AW'($urandom), rv, rt, 1'($urandom));
         n_checks++;
         if ({bp_update, bp_predict, resolve_ready, fetch_ready} !== {e_upd, e_prd, e_upd, e_prd}) begin
            n_fail++;
            $display("FAIL rnd_strobes c=%0d: got upd/prd/rr/fr=%b%b%b%b want %b%b%b%b", c,
                     bp_update, bp_predict, resolve_ready, fetch_ready, e_upd, e_prd, e_upd, e_prd);
         end
         if (e_upd || e_prd) begin
            n_checks++;
            if ({bp_addr, bp_result & bp_update} !== {e_bpa, e_bpr & e_upd}) begin
               n_fail++;
               $display("FAIL rnd_bp_bus c=%0d: got addr=%h res=%b want %h %b", c,
                        bp_addr, bp_result, e_bpa, e_bpr);
            end
         end
         n_checks++;
         if (pred_valid !== e_pv || (e_pv && {pred_taken, pred_addr} !== {e_ppred, m_lat})) begin
            n_fail++;
            $display("FAIL rnd_pred c=%0d: got pv=%b pt=%b pa=%h want %b %b %h", c,
                     pred_valid, pred_taken, pred_addr, e_pv, e_ppred, m_lat);
         end
         n_checks++;
         if (mispredict !== m_misp || (m_mc != 0 && mispredict_addr !== m_misp_addr)) begin
            n_fail++;
            $display("FAIL rnd_misp c=%0d: got mp=%b mpa=%h want %b %h", c,
                     mispredict, mispredict_addr, m_misp, m_misp_addr);
         end
         n_checks++;
         if ({branch_count, mispredict_count} !== {CW'(m_bc), CW'(m_mc)}) begin
            n_fail++;
            $display("FAIL rnd_counts c=%0d: got bc=%0d mc=%0d want %0d %0d", c,
                     branch_count, mispredict_count, m_bc, m_mc);
         end
      end
      drain();
   endtask

   task automatic test_saturation();
      logic bpp;
      while (m_mc < CMAX + 2 && n_checks < 100000) begin
         bpp = 1'($urandom);
         drive(1'b1, AW'($urandom), 1'b0, 1'b0, 1'b0);
         drive(1'b0, '0, 1'b0, 1'b0, bpp);
         drive(1'b0, '0, 1'b1, ~bpp, 1'b0);
         commit();
         if (m_mc >= CMAX) m_mc++;
      end
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if ({branch_count, mispredict_count} !== {CW'(CMAX), CW'(CMAX)}) begin
         n_fail++;
         $display("FAIL saturate: got bc=%0d mc=%0d want %0d %0d", branch_count, mispredict_count, CMAX, CMAX);
      end
      m_mc = CMAX;
      drain();
   endtask

   task automatic test_async_reset();
      drive(1'b1, 11'h055, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 11'h066, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 11'h077, 1'b0, 1'b0, 1'b1);
      #2;
      reset_n       = 1'b0;
      fetch_valid   = 1'b0;
      resolve_valid = 1'b1;
      #1;
      model_reset();
      n_checks++;
      if ({pred_valid, mispredict, bp_update, resolve_ready, branch_count, mispredict_count} !== '0) begin
         n_fail++;
         $display("FAIL async_reset: got pv=%b mp=%b bpu=%b rr=%b bc=%0d mc=%0d want all 0",
                  pred_valid, mispredict, bp_update, resolve_ready, branch_count, mispredict_count);
      end
      @(negedge clock);
      reset_n = 1'b1;
      drive(1'b1, 11'h044, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if ({bp_predict, bp_update, bp_addr} !== {1'b1, 1'b0, 11'h044}) begin
         n_fail++;
         $display("FAIL post_reset_predict: got bpp=%b bpu=%b addr=%h want 1 0 044",
                  bp_predict, bp_update, bp_addr);
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_predict();
      test_resolve();
      test_back_to_back();
      test_full();
      test_mispredict();
      test_random();
      test_saturation();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
